// File: rtl/sum_checker_if.sv
// Tap and status bundle between the adder-side logic and the sum checker.
// The checker consumes operand/result taps and publishes its verdict signals.
interface sum_checker_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) ();

  logic             in_valid;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic             clr;

  logic             chk_pulse;
  logic             err_pulse;
  logic             error;
  logic [CNT_W-1:0] match_cnt;
  logic [CNT_W-1:0] mismatch_cnt;
  logic [WIDTH-1:0] first_exp;
  logic [WIDTH-1:0] first_got;
  logic             busy;

  modport master (
    output in_valid, a, b, c, clr,
    input  chk_pulse, err_pulse, error, match_cnt, mismatch_cnt,
           first_exp, first_got, busy
  );

  modport slave (
    input  in_valid, a, b, c, clr,
    output chk_pulse, err_pulse, error, match_cnt, mismatch_cnt,
           first_exp, first_got, busy
  );

endinterface

// File: rtl/sum_checker.sv
// Result checker for a registered adder: delays a+b by LATENCY cycles, compares
// against the observed result, counts matches/mismatches and latches the first failure.
//
// state | meaning
// IDLE  | nothing in flight, no error recorded
// CHECK | operand pairs in flight, no error recorded
// FAIL  | at least one mismatch since reset/clr; checking continues
module sum_checker #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1,
  parameter int CNT_W   = 16
) (
  input  logic         clk,
  input  logic         reset,
  sum_checker_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CHECK = 2'd1,
    FAIL  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_e                          state_q, state_d;
  logic [LATENCY-1:0]              vld_q, vld_d;
  logic [LATENCY-1:0][WIDTH-1:0]   sum_q, sum_d;

  logic             chk_pulse_q, chk_pulse_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;
  logic [CNT_W-1:0] mismatch_cnt_q, mismatch_cnt_d;
  logic [WIDTH-1:0] first_exp_q, first_exp_d;
  logic [WIDTH-1:0] first_got_q, first_got_d;

  logic             vld_last;
  logic [WIDTH-1:0] exp_last;
  logic             cmp_en;
  logic             miss;
  logic             pipe_idle_d;

  // Expected-sum delay line; the WIDTH-wide sum drops the adder carry-out.
  always_comb begin
    vld_d    = '0;
    sum_d    = '0;
    vld_d[0] = bus.in_valid;
    sum_d[0] = bus.a + bus.b;
    for (int i = 1; i < LATENCY; i++) begin
      vld_d[i] = vld_q[i-1];
      sum_d[i] = sum_q[i-1];
    end
  end

  assign vld_last    = vld_q[LATENCY-1];
  assign exp_last    = sum_q[LATENCY-1];
  assign cmp_en      = vld_last && !bus.clr;
  assign miss        = cmp_en && (bus.c != exp_last);
  assign pipe_idle_d = ~|vld_d;

  // Verdict registers; a clear in the compare cycle swallows that compare.
  always_comb begin
    chk_pulse_d    = cmp_en;
    err_pulse_d    = miss;
    match_cnt_d    = match_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    first_exp_d    = first_exp_q;
    first_got_d    = first_got_q;
    if (bus.clr) begin
      match_cnt_d    = '0;
      mismatch_cnt_d = '0;
      first_exp_d    = '0;
      first_got_d    = '0;
    end else if (cmp_en) begin
      if (miss) begin
        if (mismatch_cnt_q != CNT_MAX) begin
          mismatch_cnt_d = mismatch_cnt_q + 1'b1;
        end
        if (state_q != FAIL) begin
          first_exp_d = exp_last;
          first_got_d = bus.c;
        end
      end else if (match_cnt_q != CNT_MAX) begin
        match_cnt_d = match_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (miss)              state_d = FAIL;
        else if (bus.in_valid) state_d = CHECK;
      end
      CHECK: begin
        if (miss)             state_d = FAIL;
        else if (pipe_idle_d) state_d = IDLE;
      end
      FAIL: begin
        if (bus.clr) state_d = pipe_idle_d ? IDLE : CHECK;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      vld_q          <= '0;
      sum_q          <= '0;
      chk_pulse_q    <= 1'b0;
      err_pulse_q    <= 1'b0;
      match_cnt_q    <= '0;
      mismatch_cnt_q <= '0;
      first_exp_q    <= '0;
      first_got_q    <= '0;
    end else begin
      state_q        <= state_d;
      vld_q          <= vld_d;
      sum_q          <= sum_d;
      chk_pulse_q    <= chk_pulse_d;
      err_pulse_q    <= err_pulse_d;
      match_cnt_q    <= match_cnt_d;
      mismatch_cnt_q <= mismatch_cnt_d;
      first_exp_q    <= first_exp_d;
      first_got_q    <= first_got_d;
    end
  end

  assign bus.chk_pulse    = chk_pulse_q;
  assign bus.err_pulse    = err_pulse_q;
  assign bus.error        = (state_q == FAIL);
  assign bus.match_cnt    = match_cnt_q;
  assign bus.mismatch_cnt = mismatch_cnt_q;
  assign bus.first_exp    = first_exp_q;
  assign bus.first_got    = first_got_q;
  assign bus.busy         = |vld_q;

endmodule

// File: tb/tb_sum_checker.sv
// Bench for sum_checker: directed scenarios plus randomized traffic checked
// against a cycle-level arithmetic model of the checker's verdicts.
module tb_sum_checker;

  localparam int LAT = 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sum_checker_if #(.WIDTH(8), .CNT_W(16)) bus0 ();
  sum_checker_if #(.WIDTH(8), .CNT_W(2))  bus1 ();

  sum_checker #(.WIDTH(8), .LATENCY(1), .CNT_W(16)) u_dut (
    .clk(clk), .reset(reset), .bus(bus0));
  sum_checker #(.WIDTH(8), .LATENCY(3), .CNT_W(2)) u_small (
    .clk(clk), .reset(reset), .bus(bus1));

  int total_cnt = 0;
  int pass_cnt  = 0;

  // Model of the main instance: history of issued pairs plus verdict state.
  logic [8:0]  hist[$];
  logic [15:0] m_match, m_mis;
  logic [7:0]  m_fexp, m_fgot;
  logic        m_error, m_chk, m_errp;
  logic [7:0]  b2b_exp3, b2b_bad3;

  function automatic logic model_busy();
    foreach (hist[i]) if (hist[i][8]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic model_reset();
    hist.delete();
    repeat (LAT) hist.push_back(9'd0);
    m_match = 0; m_mis = 0; m_fexp = 0; m_fgot = 0;
    m_error = 0; m_chk = 0; m_errp = 0;
  endtask

  // Drive one cycle on the main instance, advance the model, return #1 after the edge.
  task automatic cycle(input bit v, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input bit clr);
    logic [8:0] item;
    int s;
    bus0.in_valid = v; bus0.a = a; bus0.b = b; bus0.c = c; bus0.clr = clr;
    item = hist.pop_front();
    s = int'(a) + int'(b);
    hist.push_back({v, 8'(s % 256)});
    m_chk = 0; m_errp = 0;
    if (clr) begin
      m_match = 0; m_mis = 0; m_error = 0; m_fexp = 0; m_fgot = 0;
    end else if (item[8]) begin
      m_chk = 1;
      if (c != item[7:0]) begin
        m_errp = 1;
        if (m_mis != 16'hFFFF) m_mis++;
        if (!m_error) begin m_fexp = item[7:0]; m_fgot = c; end
        m_error = 1;
      end else if (m_match != 16'hFFFF) m_match++;
    end
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    bus0.in_valid = 0; bus0.clr = 0; bus1.in_valid = 0; bus1.clr = 0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [51:0] got0;
    logic [27:0] got1;
    do_reset(2);
    got0 = {bus0.chk_pulse, bus0.err_pulse, bus0.error, bus0.busy, bus0.first_exp,
            bus0.first_got, bus0.match_cnt, bus0.mismatch_cnt};
    got1 = {bus1.chk_pulse, bus1.err_pulse, bus1.error, bus1.busy, bus1.first_exp,
            bus1.first_got, bus1.match_cnt, bus1.mismatch_cnt};
    total_cnt++;
    if (got0 !== '0) $display("FAIL reset_main got=%h exp=0", got0); else pass_cnt++;
    total_cnt++;
    if (got1 !== '0) $display("FAIL reset_small got=%h exp=0", got1); else pass_cnt++;
  endtask

  task automatic test_basic();
    cycle(1, 8'd3, 8'd4, 8'd0, 0);
    total_cnt++;
    if (bus0.chk_pulse !== 1'b0) $display("FAIL basic_early_chk got=%b exp=0", bus0.chk_pulse);
    else pass_cnt++;
    cycle(0, 8'd0, 8'd0, 8'd7, 0);
    total_cnt++;
    if ({bus0.chk_pulse, bus0.err_pulse, bus0.error} !== 3'b100)
      $display("FAIL basic_pulses got=%b exp=100", {bus0.chk_pulse, bus0.err_pulse, bus0.error});
    else pass_cnt++;
    total_cnt++;
    if (bus0.match_cnt !== 16'd1) $display("FAIL basic_match_cnt got=%0d exp=1", bus0.match_cnt);
    else pass_cnt++;
  endtask

  task automatic test_wrap();
    cycle(1, 8'd200, 8'd100, 8'd0, 0);
    cycle(0, 8'd0, 8'd0, 8'd44, 0);
    total_cnt++;
    if ({bus0.chk_pulse, bus0.err_pulse, bus0.match_cnt} !== {2'b10, 16'd2})
      $display("FAIL wrap_match got=%b/%b/%0d exp=1/0/2", bus0.chk_pulse, bus0.err_pulse, bus0.match_cnt);
    else pass_cnt++;
    cycle(1, 8'd200, 8'd100, 8'd0, 0);
    cycle(0, 8'd0, 8'd0, 8'd45, 0);
    total_cnt++;
    if ({bus0.err_pulse, bus0.error, bus0.mismatch_cnt} !== {2'b11, 16'd1})
      $display("FAIL wrap_err got=%b/%b/%0d exp=1/1/1", bus0.err_pulse, bus0.error, bus0.mismatch_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus0.first_exp !== 8'd44 || bus0.first_got !== 8'd45)
      $display("FAIL wrap_first got=%0d/%0d exp=44/45", bus0.first_exp, bus0.first_got);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] pa[7], pb[7], pe[7];
    logic [7:0] cval;
    cycle(0, 8'd0, 8'd0, 8'd0, 1);
    for (int i = 0; i < 7; i++) begin
      pa[i] = 8'($urandom_range(0, 10));
      pb[i] = 8'($urandom_range(0, 10));
      pe[i] = 8'(int'(pa[i]) + int'(pb[i]));
    end
    b2b_exp3 = pe[2];
    b2b_bad3 = pe[2] + 8'd1;
    for (int k = 0; k < 8; k++) begin
      cval = (k == 0) ? 8'd0 : ((k == 3) ? b2b_bad3 : pe[k-1]);
      if (k < 7) cycle(1, pa[k], pb[k], cval, 0);
      else       cycle(0, 8'd0, 8'd0, cval, 0);
      if (k > 0) begin
        total_cnt++;
        if ({bus0.chk_pulse, bus0.err_pulse} !== {1'b1, k == 3})
          $display("FAIL b2b_pulse_%0d got=%b%b exp=1%b", k, bus0.chk_pulse, bus0.err_pulse, k == 3);
        else pass_cnt++;
      end
    end
    total_cnt++;
    if (bus0.match_cnt !== 16'd6 || bus0.mismatch_cnt !== 16'd1)
      $display("FAIL b2b_counts got=%0d/%0d exp=6/1", bus0.match_cnt, bus0.mismatch_cnt);
    else pass_cnt++;
    total_cnt++;
    if (bus0.first_exp !== b2b_exp3 || bus0.first_got !== b2b_bad3)
      $display("FAIL b2b_first got=%0d/%0d exp=%0d/%0d", bus0.first_exp, bus0.first_got, b2b_exp3, b2b_bad3);
    else pass_cnt++;
  endtask

  task automatic test_second_mismatch_clr();
    logic [51:0] got;
    cycle(1, 8'd5, 8'd5, 8'd0, 0);
    cycle(0, 8'd0, 8'd0, 8'd0, 0);
    total_cnt++;
    if (bus0.mismatch_cnt !== 16'd2 || bus0.err_pulse !== 1'b1)
      $display("FAIL second_mis got=%0d/%b exp=2/1", bus0.mismatch_cnt, bus0.err_pulse);
    else pass_cnt++;
    total_cnt++;
    if (bus0.first_exp !== b2b_exp3 || bus0.first_got !== b2b_bad3)
      $display("FAIL second_first got=%0d/%0d exp=%0d/%0d", bus0.first_exp, bus0.first_got, b2b_exp3, b2b_bad3);
    else pass_cnt++;
    cycle(0, 8'd0, 8'd0, 8'd0, 1);
    got = {bus0.chk_pulse, bus0.err_pulse, bus0.error, bus0.busy, bus0.first_exp,
           bus0.first_got, bus0.match_cnt, bus0.mismatch_cnt};
    total_cnt++;
    if (got !== '0) $display("FAIL clr_all_zero got=%h exp=0", got); else pass_cnt++;
    // Pair issued before clr; its compare lands in the clr cycle and is dropped.
    cycle(1, 8'd2, 8'd3, 8'd0, 0);
    cycle(1, 8'd4, 8'd4, 8'd5, 1);
    total_cnt++;
    if ({bus0.chk_pulse, bus0.busy, bus0.match_cnt} !== {2'b01, 16'd0})
      $display("FAIL clr_drop got=%b/%b/%0d exp=0/1/0", bus0.chk_pulse, bus0.busy, bus0.match_cnt);
    else pass_cnt++;
    cycle(0, 8'd0, 8'd0, 8'd8, 0);
    total_cnt++;
    if ({bus0.chk_pulse, bus0.err_pulse, bus0.match_cnt, bus0.busy} !== {2'b10, 16'd1, 1'b0})
      $display("FAIL clr_keep_pipe got=%b/%b/%0d/%b exp=1/0/1/0", bus0.chk_pulse, bus0.err_pulse,
               bus0.match_cnt, bus0.busy);
    else pass_cnt++;
  endtask

  task automatic test_random();
    logic [51:0] got, exp;
    logic [7:0]  a, b, c;
    bit          v, clr;
    for (int n = 0; n < 80; n++) begin
      v   = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      a   = 8'($urandom);
      b   = 8'($urandom);
      if (hist[0][8]) c = ($urandom_range(0, 3) != 0) ? hist[0][7:0]
                                                      : hist[0][7:0] + 8'($urandom_range(1, 255));
      else c = 8'($urandom);
      cycle(v, a, b, c, clr);
      got = {bus0.chk_pulse, bus0.err_pulse, bus0.error, bus0.busy, bus0.first_exp,
             bus0.first_got, bus0.match_cnt, bus0.mismatch_cnt};
      exp = {m_chk, m_errp, m_error, model_busy(), m_fexp, m_fgot, m_match, m_mis};
      total_cnt++;
      if (got !== exp) $display("FAIL random_%0d got=%h exp=%h", n, got, exp); else pass_cnt++;
    end
  endtask

  task automatic test_reset_inflight();
    cycle(1, 8'd7, 8'd8, 8'd0, 0);
    bus0.c = 8'd15;
    do_reset(1);
    total_cnt++;
    if ({bus0.chk_pulse, bus0.busy, bus0.match_cnt, bus0.mismatch_cnt} !== '0)
      $display("FAIL reset_inflight got=%b/%b/%0d/%0d exp=0/0/0/0", bus0.chk_pulse, bus0.busy,
               bus0.match_cnt, bus0.mismatch_cnt);
    else pass_cnt++;
    cycle(0, 8'd0, 8'd0, 8'd15, 0);
    total_cnt++;
    if ({bus0.chk_pulse, bus0.match_cnt} !== '0)
      $display("FAIL reset_inflight_after got=%b/%0d exp=0/0", bus0.chk_pulse, bus0.match_cnt);
    else pass_cnt++;
  endtask

  task automatic test_saturate();
    int pulses = 0;
    int first_at = -1;
    do_reset(2);
    bus1.a = 8'd1; bus1.b = 8'd2; bus1.c = 8'd3;
    for (int k = 0; k < 15; k++) begin
      bus1.in_valid = (k < 5);
      cycle(0, 8'd0, 8'd0, 8'd0, 0);
      if (bus1.chk_pulse === 1'b1) begin
        pulses++;
        if (first_at < 0) first_at = k;
      end
    end
    bus1.in_valid = 1'b0;
    total_cnt++;
    if (pulses != 5 || first_at != 3)
      $display("FAIL sat_pulses got=%0d@%0d exp=5@3", pulses, first_at);
    else pass_cnt++;
    total_cnt++;
    if (bus1.match_cnt !== 2'd3 || bus1.mismatch_cnt !== 2'd0 || bus1.error !== 1'b0 || bus1.busy !== 1'b0)
      $display("FAIL sat_counts got=%0d/%0d/%b/%b exp=3/0/0/0", bus1.match_cnt, bus1.mismatch_cnt,
               bus1.error, bus1.busy);
    else pass_cnt++;
  endtask

  initial begin
    bus0.in_valid = 0; bus0.a = 0; bus0.b = 0; bus0.c = 0; bus0.clr = 0;
    bus1.in_valid = 0; bus1.a = 0; bus1.b = 0; bus1.c = 0; bus1.clr = 0;
    test_reset();
    test_basic();
    test_wrap();
    test_back_to_back();
    test_second_mismatch_clr();
    test_random();
    test_reset_inflight();
    test_saturate();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
